// File: rtl/sdram_write.sv
// Write-burst sequencer: ACTIVE, full-page WRITE streaming wr_bst_len words, burst terminate,
// write recovery, PRECHARGE, then a one-cycle completion pulse.
module sdram_write #(
  parameter int unsigned TRCD = 2,
  parameter int unsigned TWR  = 2,
  parameter int unsigned TRP  = 2
) (
  input  logic        wr_clk,
  input  logic        wr_rst_n,
  input  logic        wr_en,
  input  logic [23:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [9:0]  wr_bst_len,
  input  logic        init_end,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  wr_sdram_cmd,
  output logic [1:0]  wr_sdram_bank,
  output logic [12:0] wr_sdram_addr,
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdBst = 4'b0110;
  localparam logic [3:0] CmdPre = 4'b0010;

  localparam logic [9:0] TrcdLast = 10'(TRCD);
  localparam logic [9:0] TwrLast  = 10'(TWR - 1);
  localparam logic [9:0] TrpLast  = 10'(TRP);

  typedef enum logic [3:0] {
    StIdle, StAct, StTrcd, StWr, StData, StTwr, StPre, StTrp, StEnd
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  cnt_q;
  logic [23:0] addr_q;
  logic [9:0]  len_q;
  logic [9:0]  len_m1;

  assign len_m1 = len_q - 10'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (init_end && wr_en) state_d = StAct;
      StAct:   state_d = StTrcd;
      StTrcd:  if (cnt_q == TrcdLast) state_d = StWr;
      StWr:    state_d = StData;
      StData:  if (cnt_q == len_m1) state_d = StTwr;
      StTwr:   if (cnt_q == TwrLast) state_d = StPre;
      StPre:   state_d = StTrp;
      StTrp:   if (cnt_q == TrpLast) state_d = StEnd;
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The last DATA cycle carries BST instead of a word, so ack stops one count early.
  assign wr_ack = (state_q == StWr) || ((state_q == StData) && (cnt_q < len_m1));
  assign wr_end = (state_q == StEnd);

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      len_q         <= 10'd1;
      wr_sdram_cmd  <= CmdNop;
      wr_sdram_bank <= 2'b11;
      wr_sdram_addr <= 13'h1fff;
      wr_sdram_en   <= 1'b0;
      wr_sdram_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 10'd0 : cnt_q + 10'd1;

      if ((state_q == StIdle) && (state_d == StAct)) begin
        addr_q <= wr_addr;
        len_q  <= (wr_bst_len == 10'd0) ? 10'd1 : wr_bst_len;
      end

      wr_sdram_cmd  <= CmdNop;
      wr_sdram_bank <= 2'b11;
      wr_sdram_addr <= 13'h1fff;
      case (state_q)
        StAct: begin
          wr_sdram_cmd  <= CmdAct;
          wr_sdram_bank <= addr_q[23:22];
          wr_sdram_addr <= addr_q[21:9];
        end
        StWr: begin
          wr_sdram_cmd  <= CmdWr;
          wr_sdram_bank <= addr_q[23:22];
          wr_sdram_addr <= {4'b0000, addr_q[8:0]};
        end
        StData: begin
          if (cnt_q == len_m1) wr_sdram_cmd <= CmdBst;
        end
        StPre: begin
          wr_sdram_cmd  <= CmdPre;
          wr_sdram_bank <= addr_q[23:22];
          wr_sdram_addr <= 13'h0400;
        end
        default: ;
      endcase

      wr_sdram_en   <= wr_ack;
      wr_sdram_data <= wr_ack ? wr_data : 16'h0000;
    end
  end

endmodule

// File: doc/sdram_write.md
# sdram_write

Write-burst sequencer for the SDRAM controller, the counterpart of the read sequencer on the same command bus. On a write request after initialization it issues ACTIVE, waits tRCD, issues WRITE in full-page mode while streaming `wr_bst_len` 16-bit words from the user side, terminates the burst, honours tWR, precharges the bank, waits tRP and reports completion. Its command, bank, address and data outputs feed the controller's arbiter/mux, which drives the SDRAM pins.

## Interface
- `TRCD`, 2, ACTIVE→WRITE wait; the TRCD state lasts TRCD+1 cycles
- `TWR`, 2, last data word→PRECHARGE recovery, in cycles
- `TRP`, 2, PRECHARGE→done wait; the TRP state lasts TRP+1 cycles
- `wr_clk` in 1: the only clock, rising edge
- `wr_rst_n` in 1: reset, synchronous, active-low
- `wr_en` in 1: write request; sampled only in IDLE
- `wr_addr` in 24: {bank[23:22], row[21:9], column[8:0]}
- `wr_data` in 16: user write data; consumed on cycles where `wr_ack`=1
- `wr_bst_len` in 10: burst length in words, legal 1..512
- `init_end` in 1: SDRAM initialization complete
- `wr_ack` out 1: data request/accept strobe (combinational from state/counter)
- `wr_end` out 1: one-cycle completion pulse
- `wr_sdram_cmd` out 4: {CS#,RAS#,CAS#,WE#}: NOP 0111, ACT 0011, WR 0100, BST 0110, PRE 0010
- `wr_sdram_bank` out 2: bank address
- `wr_sdram_addr` out 13: row/column/A10
- `wr_sdram_en` out 1: data-bus drive enable
- `wr_sdram_data` out 16: data to DQ

## Operation
- FSM states: IDLE, ACT, TRCD, WR, DATA, TWR, PRE, TRP, END. One 10-bit cycle counter, cleared on every state change.
- IDLE→ACT when `init_end && wr_en`. On that edge, `wr_addr` and `wr_bst_len` are latched into internal registers; a latched length of 0 is treated as 1. Inputs are ignored after the latch until the next IDLE.
- ACT→TRCD after one cycle. TRCD→WR when cnt==TRCD. WR→DATA after one cycle.
- DATA→TWR when cnt==L-1, where L is the latched length. TWR→PRE when cnt==TWR-1. PRE→TRP after one cycle. TRP→END when cnt==TRP. END→IDLE after one cycle.
- `wr_ack`=1 in the WR state, and in DATA while cnt<L-1. This gives exactly L ack cycles.
- `wr_end`=1 only in END.
- Command outputs are registered from the current state:
  - ACT: cmd ACT, bank=addr[23:22], addr=addr[21:9]
  - WR: cmd WR, bank=addr[23:22], addr={4'b0000, addr[8:0]}
  - DATA with cnt==L-1: cmd BST
  - PRE: cmd PRE, bank=addr[23:22], addr=13'h0400 (A10=1)
  - all other cycles: NOP, bank 2'b11, addr 13'h1fff
- Data outputs are registered: `wr_sdram_en` <= `wr_ack`; `wr_sdram_data` <= `wr_ack` ? `wr_data` : 16'h0000.
- The column wraps within the row (511→0) under full-page mode. The block never splits a burst across rows.
- `wr_en` asserted during a burst has no effect. It is re-evaluated in IDLE on the cycle after END.
- `init_end` low: the block stays in IDLE regardless of `wr_en`.

## Timing
- Cycle 0 is the IDLE edge where `init_end && wr_en` is sampled. L is the latched length.
- State schedule:
  - ACT state: cycle 1
  - TRCD: cycles 2..2+TRCD
  - WR: cycle 3+TRCD
  - DATA: cycles 4+TRCD..3+TRCD+L
  - TWR: TWR cycles
  - PRE: cycle 4+TRCD+L+TWR
  - TRP: TRP+1 cycles
  - END: cycle 6+TRCD+L+TWR+TRP
- Pin-side timing (one cycle after the state):
  - ACT command in cycle 2.
  - WR command with data word 0 in cycle 4+TRCD.
  - Words 1..L-1 in the following consecutive cycles, with `wr_sdram_en`=1 throughout.
  - BST in cycle 4+TRCD+L, the first cycle after the last word, with en=0.
  - PRE in cycle 5+TRCD+L+TWR.
- Each word is consumed on its `wr_ack` cycle and appears on `wr_sdram_data` the next cycle.
- Total duration: cycle 0 to the `wr_end` cycle is 6+TRCD+L+TWR+TRP cycles.
- Reset: any cycle with `wr_rst_n`=0 sets, on that edge:
  - state IDLE, counter 0
  - cmd NOP, bank 2'b11, addr 13'h1fff
  - en 0, data 0
  - `wr_ack`, `wr_end` therefore 0 from the next cycle
- Reset mid-burst aborts with no PRE; the controller must re-initialize or precharge.

## Test plan
- Defaults, L=4, addr=24'hC0A005, data 1,2,3,4:
  - ACT on pins in cycle 2, bank 3, row 13'h0050.
  - WR in cycle 6, col 13'h0005.
  - Data 1..4 in cycles 6..9; ack in cycles 5..8.
  - BST in cycle 10; PRE (addr 13'h0400) in cycle 13; `wr_end` in cycle 16.
- L=1: single ack in cycle 5, one data word in cycle 6, BST in cycle 7, `wr_end` in cycle 13. Also check L=0 behaves identically to L=1.
- L=512, column 9'h1F0: exactly 512 consecutive ack and en cycles; BST immediately after the last word; no row change.
- `init_end`=0 with `wr_en`=1 held for 10 cycles: output stays NOP/2'b11/13'h1fff, ack and end stay 0. Raising `init_end` then starts ACT state 1 cycle later.
- `wr_en` held high continuously: back-to-back bursts, the next ACT state in the cycle after IDLE follows END. Changing `wr_addr`/`wr_bst_len` mid-burst does not alter the current burst.
- Reset asserted in cycle 7 of a burst: from cycle 8, all outputs are at reset values and state is IDLE. A new request then completes normally.
